// File: rtl/mvu_dot_accumulator.sv
// MVU compute stage: joins the replayed activation stream with the weight stream,
// forms a SIMD-lane signed dot product per item pair and accumulates it per sequence.

module mvu_dot_lane #(
  parameter int AW   = 8,
  parameter int WW   = 8,
  parameter int ACCW = 24
) (
  input  logic signed [AW-1:0]   i_a,
  input  logic signed [WW-1:0]   i_w,
  output logic signed [ACCW-1:0] o_p
);
  logic signed [AW+WW-1:0] w_prod;

  // Full-precision product, then sign-extended into the accumulator width.
  assign w_prod = (AW+WW)'(i_a) * (AW+WW)'(i_w);
  assign o_p    = ACCW'(w_prod);
endmodule

module mvu_dot_accumulator #(
  parameter int SIMD = 4,
  parameter int AW   = 8,
  parameter int WW   = 8,
  parameter int ACCW = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SIMD*AW-1:0]   a_dat,
  input  logic                 a_last,
  input  logic                 a_fin,
  input  logic                 a_vld,
  output logic                 a_rdy,
  input  logic [SIMD*WW-1:0]   w_dat,
  input  logic                 w_vld,
  output logic                 w_rdy,
  output logic [ACCW-1:0]      odat,
  output logic                 ofin,
  output logic                 ovld,
  input  logic                 ordy
);
  localparam int STAGES = 2;

  if (ACCW < AW + WW) begin : g_bad_accw
    $error("mvu_dot_accumulator: ACCW (%0d) must be >= AW+WW (%0d)", ACCW, AW + WW);
  end

  logic                      w_en;
  logic                      w_take;
  logic [STAGES:1]           r_vld_pipe;  // [1] item in stage 2, [2] result held at output
  logic [SIMD-1:0][ACCW-1:0] w_prod;
  logic [ACCW-1:0]           w_dot;
  logic [ACCW-1:0]           w_sum;
  logic [ACCW-1:0]           r_dot;
  logic [ACCW-1:0]           r_acc;
  logic [ACCW-1:0]           r_odat;
  logic                      r_l1;
  logic                      r_f1;
  logic                      r_ofin;

  // Whole pipeline advances together; only a held, unconsumed result stalls it.
  assign w_en   = !r_vld_pipe[STAGES] || ordy;
  assign a_rdy  = w_vld && w_en;
  assign w_rdy  = a_vld && w_en;
  assign w_take = a_vld && w_vld && w_en;

  for (genvar i = 0; i < SIMD; i++) begin : g_lane
    mvu_dot_lane #(
      .AW   (AW),
      .WW   (WW),
      .ACCW (ACCW)
    ) u_lane (
      .i_a (a_dat[i*AW +: AW]),
      .i_w (w_dat[i*WW +: WW]),
      .o_p (w_prod[i])
    );
  end

  // Lane products are already sign-extended, so a modular ACCW-bit sum is exact mod 2^ACCW.
  always_comb begin
    w_dot = '0;
    for (int i = 0; i < SIMD; i++) w_dot = w_dot + w_prod[i];
  end

  assign w_sum = r_acc + r_dot;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_pipe <= '0;
      r_dot      <= '0;
      r_l1       <= 1'b0;
      r_f1       <= 1'b0;
      r_acc      <= '0;
      r_odat     <= '0;
      r_ofin     <= 1'b0;
    end else if (w_en) begin
      r_vld_pipe <= {r_vld_pipe[1] && r_l1, w_take};
      r_dot      <= w_dot;
      r_l1       <= a_last;
      r_f1       <= a_fin;
      if (r_vld_pipe[1]) begin
        if (r_l1) begin
          r_odat <= w_sum;
          r_ofin <= r_f1;
          r_acc  <= '0;
        end else begin
          r_acc  <= w_sum;
        end
      end
    end
  end

  assign odat = r_odat;
  assign ofin = r_ofin;
  assign ovld = r_vld_pipe[STAGES];
endmodule

// File: tb/tb_mvu_dot_accumulator.sv
// Bench for mvu_dot_accumulator: directed scenarios plus a randomized stream checked
// against a per-sequence sum model; a 16-bit and an 8-bit accumulator share the stimulus.

module tb_mvu_dot_accumulator;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a_dat, w_dat;
  logic       a_last, a_fin, a_vld, w_vld, ordy;
  logic       a_rdy16, w_rdy16, ovld16, ofin16;
  logic [15:0] odat16;
  logic       a_rdy8, w_rdy8, ovld8, ofin8;
  logic [7:0] odat8;
  int         ntests = 0;
  int         nfail  = 0;

  always #5 clk = ~clk;

  mvu_dot_accumulator #(.SIMD(2), .AW(4), .WW(4), .ACCW(16)) u_dut16 (
    .clk(clk), .rst(rst), .a_dat(a_dat), .a_last(a_last), .a_fin(a_fin),
    .a_vld(a_vld), .a_rdy(a_rdy16), .w_dat(w_dat), .w_vld(w_vld), .w_rdy(w_rdy16),
    .odat(odat16), .ofin(ofin16), .ovld(ovld16), .ordy(ordy)
  );

  mvu_dot_accumulator #(.SIMD(2), .AW(4), .WW(4), .ACCW(8)) u_dut8 (
    .clk(clk), .rst(rst), .a_dat(a_dat), .a_last(a_last), .a_fin(a_fin),
    .a_vld(a_vld), .a_rdy(a_rdy8), .w_dat(w_dat), .w_vld(w_vld), .w_rdy(w_rdy8),
    .odat(odat8), .ofin(ofin8), .ovld(ovld8), .ordy(ordy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pk(input int x0, input int x1);
    logic [31:0] a, b;
    a = x0;
    b = x1;
    return {b[3:0], a[3:0]};
  endfunction

  task automatic put(input int a0, input int a1, input int w0, input int w1,
                     input bit l, input bit f, input bit av, input bit wv);
    a_dat  = pk(a0, a1);
    w_dat  = pk(w0, w1);
    a_last = l;
    a_fin  = f;
    a_vld  = av;
    w_vld  = wv;
  endtask

  task automatic idle();
    a_vld  = 1'b0;
    w_vld  = 1'b0;
    a_last = 1'b0;
    a_fin  = 1'b0;
  endtask

  task automatic chk_res(input string tag, input bit v, input int val, input bit fin);
    logic [31:0] e;
    e = val;
    chk({tag, "_vld16"}, {31'b0, ovld16}, {31'b0, v});
    chk({tag, "_vld8"},  {31'b0, ovld8},  {31'b0, v});
    if (v) begin
      chk({tag, "_dat16"}, {16'b0, odat16}, {16'b0, e[15:0]});
      chk({tag, "_dat8"},  {24'b0, odat8},  {24'b0, e[7:0]});
      chk({tag, "_fin"},   {31'b0, ofin16}, {31'b0, fin});
    end
  endtask

  task automatic chk_rdy(input string tag, input bit ar, input bit wr);
    chk({tag, "_ardy"}, {31'b0, a_rdy16}, {31'b0, ar});
    chk({tag, "_wrdy"}, {31'b0, w_rdy16}, {31'b0, wr});
    chk({tag, "_ardy8"}, {31'b0, a_rdy8}, {31'b0, ar});
  endtask

  initial begin
    int qa0[$], qa1[$], qw0[$], qw1[$];
    bit ql[$], qf[$];
    int esum[$];
    bit efin[$];
    int run, cyc, len, x;
    bit sfin, stall_prev;
    logic [15:0] odat_prev;
    logic [31:0] e;

    rst = 1'b1; ordy = 1'b1; a_dat = '0; w_dat = '0;
    idle();
    repeat (3) @(negedge clk);
    chk_res("rst", 1'b0, 0, 1'b0);
    chk("rst_dat16", {16'b0, odat16}, 32'd0);
    chk("rst_fin", {31'b0, ofin16}, 32'd0);
    rst = 1'b0;

    // Basic accumulate: 3 + 4 + 8 = 15, result two cycles after the last item.
    put(1, 2, 1, 1, 0, 0, 1, 1);    @(negedge clk);
    put(3, -1, 2, 2, 0, 0, 1, 1);   @(negedge clk);
    put(-8, 7, -8, -8, 1, 1, 1, 1); @(negedge clk);
    idle(); chk_res("t1_lat", 1'b0, 0, 1'b0); @(negedge clk);
    chk_res("t1_res", 1'b1, 15, 1'b1);        @(negedge clk);
    chk_res("t1_drop", 1'b0, 0, 1'b0);

    // Length-1 sequences back-to-back.
    put(2, 3, 4, 5, 1, 0, 1, 1);     #1 chk_rdy("t2_i0", 1, 1); @(negedge clk);
    put(-1, -1, 1, 1, 1, 1, 1, 1);   #1 chk_rdy("t2_i1", 1, 1); @(negedge clk);
    idle(); chk_res("t2_r0", 1'b1, 23, 1'b0); @(negedge clk);
    chk_res("t2_r1", 1'b1, -2, 1'b1);         @(negedge clk);
    chk_res("t2_drop", 1'b0, 0, 1'b0);

    // Backpressure: result held five cycles, next item waits for ordy.
    ordy = 1'b0;
    put(1, 2, 1, 1, 0, 0, 1, 1);    @(negedge clk);
    put(3, -1, 2, 2, 0, 0, 1, 1);   @(negedge clk);
    put(-8, 7, -8, -8, 1, 0, 1, 1); @(negedge clk);
    idle(); chk_res("t3_lat", 1'b0, 0, 1'b0); @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      chk_res("t3_hold", 1'b1, 15, 1'b0);
      put(1, 1, 1, 1, 1, 1, 1, 1);
      #1 chk_rdy("t3_stall", 0, 0);
      @(negedge clk);
    end
    chk_res("t3_rel", 1'b1, 15, 1'b0);
    ordy = 1'b1; #1 chk_rdy("t3_go", 1, 1); @(negedge clk);
    idle(); chk_res("t3_gap", 1'b0, 0, 1'b0); @(negedge clk);
    chk_res("t3_next", 1'b1, 2, 1'b1);        @(negedge clk);

    // Stream skew: weights arrive three cycles after activations.
    for (int k = 0; k < 3; k++) begin
      put(1, 2, 1, 1, 0, 0, 1, 0);
      #1 chk_rdy("t4_skew", 0, 1);
      @(negedge clk);
    end
    put(1, 2, 1, 1, 0, 0, 1, 1);    #1 chk_rdy("t4_join", 1, 1); @(negedge clk);
    put(3, -1, 2, 2, 0, 0, 1, 1);   @(negedge clk);
    put(-8, 7, -8, -8, 1, 0, 1, 1); @(negedge clk);
    idle(); chk_res("t4_lat", 1'b0, 0, 1'b0); @(negedge clk);
    chk_res("t4_res", 1'b1, 15, 1'b0);        @(negedge clk);

    // Extreme values: 3 x 128 = 384, wraps to 0x80 in the 8-bit instance.
    put(-8, -8, -8, -8, 0, 0, 1, 1); @(negedge clk);
    put(-8, -8, -8, -8, 0, 0, 1, 1); @(negedge clk);
    put(-8, -8, -8, -8, 1, 1, 1, 1); @(negedge clk);
    idle(); chk_res("t5_lat", 1'b0, 0, 1'b0); @(negedge clk);
    chk_res("t5_wrap", 1'b1, 384, 1'b1);      @(negedge clk);

    // Reset mid-sequence: partial sum and the item offered during reset are dropped.
    put(3, 3, 3, 3, 0, 0, 1, 1); @(negedge clk);
    put(3, 3, 3, 3, 0, 0, 1, 1); @(negedge clk);
    rst = 1'b1; put(5, 5, 5, 5, 1, 1, 1, 1); @(negedge clk);
    rst = 1'b0; chk_res("t6_rst", 1'b0, 0, 1'b0);
    put(1, 1, 1, 1, 1, 0, 1, 1); @(negedge clk);
    idle(); chk_res("t6_lat", 1'b0, 0, 1'b0); @(negedge clk);
    chk_res("t6_res", 1'b1, 2, 1'b0);         @(negedge clk);

    // Randomized stream with random valid gaps and ordy.
    for (int s = 0; s < 60; s++) begin
      len  = $urandom_range(1, 5);
      sfin = 1'($urandom_range(0, 1));
      for (int k = 0; k < len; k++) begin
        x = $urandom_range(0, 15) - 8; qa0.push_back(x);
        x = $urandom_range(0, 15) - 8; qa1.push_back(x);
        x = $urandom_range(0, 15) - 8; qw0.push_back(x);
        x = $urandom_range(0, 15) - 8; qw1.push_back(x);
        ql.push_back(k == len - 1);
        qf.push_back((k == len - 1) ? sfin : 1'($urandom_range(0, 1)));
      end
    end
    run = 0; cyc = 0; stall_prev = 1'b0; odat_prev = '0;
    while ((qa0.size() > 0 || esum.size() > 0) && cyc < 5000) begin
      if (stall_prev) begin
        chk("rnd_hold_vld", {31'b0, ovld16}, 32'd1);
        chk("rnd_hold_dat", {16'b0, odat16}, {16'b0, odat_prev});
      end
      if (qa0.size() > 0)
        put(qa0[0], qa1[0], qw0[0], qw1[0], ql[0], qf[0],
            $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
      else
        idle();
      ordy = $urandom_range(0, 3) != 0;
      #1;
      chk_rdy("rnd", w_vld && (!ovld16 || ordy), a_vld && (!ovld16 || ordy));
      if (ovld16 && ordy) begin
        if (esum.size() == 0) begin
          chk("rnd_spurious", {31'b0, ovld16}, 32'd0);
        end else begin
          e = esum.pop_front();
          chk("rnd_dat16", {16'b0, odat16}, {16'b0, e[15:0]});
          chk("rnd_dat8", {24'b0, odat8}, {24'b0, e[7:0]});
          chk("rnd_fin", {31'b0, ofin16}, {31'b0, efin.pop_front()});
        end
      end
      if (a_vld && w_vld && a_rdy16) begin
        run += qa0[0] * qw0[0] + qa1[0] * qw1[0];
        if (ql[0]) begin
          esum.push_back(run);
          efin.push_back(qf[0]);
          run = 0;
        end
        void'(qa0.pop_front()); void'(qa1.pop_front());
        void'(qw0.pop_front()); void'(qw1.pop_front());
        void'(ql.pop_front());  void'(qf.pop_front());
      end
      stall_prev = ovld16 && !ordy;
      odat_prev  = odat16;
      @(negedge clk);
      cyc++;
    end
    chk("rnd_drain", qa0.size() + esum.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
